// File: rtl/ast_pkg.sv
// Shared types and default geometry for the Avalon-ST sink unpacker.
package ast_pkg;

    localparam int unsigned AST_DATABITS = 8;
    localparam int unsigned AST_SYMBOLS  = 4;
    localparam int unsigned WIDTH        = AST_DATABITS * AST_SYMBOLS;
    localparam int unsigned EMPTY_W      = $clog2(AST_SYMBOLS);

    // One buffered Avalon-ST beat with its framing sidebands.
    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } ast_beat_t;

endpackage

// File: rtl/ast_beat_buf.sv
// Synchronous DEPTH-entry beat FIFO; push is ignored when full, pop when empty.
module ast_beat_buf
    import ast_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  ast_beat_t          din_i,
    input  logic               pop_i,
    output ast_beat_t          dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [COUNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ast_beat_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags, guarded operations and head-of-queue read.
    always_comb begin
        full_o  = (count_o == COUNT_W'(DEPTH));
        empty_o = (count_o == '0);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        dout_o  = mem[rd_ptr];
    end

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din_i;
        end
    end

    // Modulo-DEPTH pointers and occupancy counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + COUNT_W'(1);
                2'b01:   count_o <= count_o - COUNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/ast_sink_unpacker.sv
// Avalon-ST sink: buffers multi-symbol beats and emits one symbol per cycle.
module ast_sink_unpacker
    import ast_pkg::*;
#(
    parameter int unsigned DATABITS_PER_SYMBOL = AST_DATABITS,
    parameter int unsigned SYMBOLS_PER_BEAT    = AST_SYMBOLS,
    parameter int unsigned READY_LATENCY       = 2,
    parameter int unsigned DEPTH               = READY_LATENCY + 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] ast_data_i,
    input  logic                                          ast_valid_i,
    input  logic                                          ast_sop_i,
    input  logic                                          ast_eop_i,
    input  logic [$clog2(SYMBOLS_PER_BEAT)-1:0]           ast_empty_i,
    output logic                                          ast_ready_o,
    output logic [DATABITS_PER_SYMBOL-1:0]                sym_data_o,
    output logic                                          sym_valid_o,
    input  logic                                          sym_ready_i,
    output logic                                          sym_sop_o,
    output logic                                          sym_eop_o,
    output logic                                          overflow_o
);

    localparam int unsigned IDX_W     = $clog2(SYMBOLS_PER_BEAT);
    localparam int unsigned COUNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned READY_MAX = DEPTH - 1 - READY_LATENCY;

    ast_beat_t                    in_beat;
    ast_beat_t                    head;
    logic                         full;
    logic                         empty;
    logic [COUNT_W-1:0]           count;
    logic [COUNT_W-1:0]           occ_next;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             last_idx;
    logic                         push;
    logic                         pop;
    logic                         sym_fire;
    logic                         at_last;
    logic [DATABITS_PER_SYMBOL-1:0] syms [SYMBOLS_PER_BEAT];

    ast_beat_buf #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (in_beat),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Symbol 0 sits in the MSBs of the beat.
    for (genvar g = 0; g < SYMBOLS_PER_BEAT; g++) begin : g_sym
        assign syms[g] = head.data[(SYMBOLS_PER_BEAT-1-g)*DATABITS_PER_SYMBOL +: DATABITS_PER_SYMBOL];
    end

    // Beat capture, unpack handshake and next-occupancy for the credit check.
    always_comb begin
        in_beat.data  = ast_data_i;
        in_beat.sop   = ast_sop_i;
        in_beat.eop   = ast_eop_i;
        in_beat.empty = ast_empty_i;

        // Full is judged on pre-pop state: a same-cycle pop does not make room.
        push     = ast_valid_i & ~full;
        last_idx = head.eop ? IDX_W'(SYMBOLS_PER_BEAT - 1) - head.empty
                            : IDX_W'(SYMBOLS_PER_BEAT - 1);
        at_last  = (idx == last_idx);
        sym_fire = ~empty & sym_ready_i;
        pop      = sym_fire & at_last;
        occ_next = count + COUNT_W'(push) - COUNT_W'(pop);

        sym_valid_o = ~empty;
        sym_data_o  = syms[idx];
        sym_sop_o   = ~empty & head.sop & (idx == '0);
        sym_eop_o   = ~empty & head.eop & at_last;
    end

    // Symbol index over the head beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx <= '0;
        end else if (sym_fire) begin
            idx <= at_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Registered ready: leave room for beats still in flight over the ready latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ast_ready_o <= 1'b0;
        end else begin
            ast_ready_o <= (occ_next <= COUNT_W'(READY_MAX));
        end
    end

    // Sticky overflow: a valid beat found the buffer full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (ast_valid_i & full) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ast_sink_unpacker.sv
// Directed, self-checking bench for ast_sink_unpacker (default geometry 8x4, RL=2, DEPTH=4).
module tb_ast_sink_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ast_data;
    logic        ast_valid;
    logic        ast_sop;
    logic        ast_eop;
    logic [1:0]  ast_empty;
    logic        ast_ready;
    logic [7:0]  sym_data;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_sop;
    logic        sym_eop;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ast_sink_unpacker #(
        .DATABITS_PER_SYMBOL (8),
        .SYMBOLS_PER_BEAT    (4),
        .READY_LATENCY       (2),
        .DEPTH               (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ast_data_i  (ast_data),
        .ast_valid_i (ast_valid),
        .ast_sop_i   (ast_sop),
        .ast_eop_i   (ast_eop),
        .ast_empty_i (ast_empty),
        .ast_ready_o (ast_ready),
        .sym_data_o  (sym_data),
        .sym_valid_o (sym_valid),
        .sym_ready_i (sym_ready),
        .sym_sop_o   (sym_sop),
        .sym_eop_o   (sym_eop),
        .overflow_o  (overflow)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        srdy;
        logic        e_rdy;
        logic        e_sv;
        logic [7:0]  e_data;
        logic        e_sop;
        logic        e_eop;
        logic        e_ov;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                                input logic s, input logic e, input logic [1:0] em,
                                input logic sr, input logic xr, input logic xv,
                                input logic [7:0] xd, input logic xs, input logic xe,
                                input logic xo);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.sop = s; t.eop = e; t.empty = em;
        t.srdy = sr; t.e_rdy = xr; t.e_sv = xv; t.e_data = xd;
        t.e_sop = xs; t.e_eop = xe; t.e_ov = xo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sym_of(input int b, input int s);
        return 8'h40 + 8'(b * 16) + 8'(s);
    endfunction

    function automatic logic [31:0] beat_word(input int b);
        return {sym_of(b, 0), sym_of(b, 1), sym_of(b, 2), sym_of(b, 3)};
    endfunction

    task automatic idle_inputs();
        ast_valid = 1'b0;
        ast_data  = '0;
        ast_sop   = 1'b0;
        ast_eop   = 1'b0;
        ast_empty = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sym_ready = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [31:0] d);
        ast_valid = 1'b1;
        ast_data  = d;
        ast_sop   = 1'b1;
        ast_eop   = 1'b1;
        ast_empty = '0;
    endtask

    // Consume symbols with sym_ready high; expect exp_n in-order symbols from first_beat.
    task automatic drain(input int first_beat, input int exp_n, input string tag);
        int rcv = 0;
        sym_ready = 1'b1;
        idle_inputs();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sym_valid) begin
                chk($sformatf("%s_sym%0d", tag, rcv), {24'h0, sym_data},
                    {24'h0, sym_of(first_beat + rcv / 4, rcv % 4)});
                rcv++;
            end
            @(negedge clk);
        end
        chk($sformatf("%s_count", tag), rcv, exp_n);
    endtask

    initial begin
        int sent;
        logic [1:0] hist;

        rst = 1'b1;
        sym_ready = 1'b0;
        idle_inputs();

        vecs[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 32'hA1B2C3D4, 1, 1, 0, 1,  1, 1, 8'hA1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'hB2, 0, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'hC3, 0, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'hD4, 0, 1, 0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, 1, 32'h11223300, 1, 1, 1, 1,  1, 1, 8'h11, 1, 0, 0);
        vecs[7]  = mk(0, 1, 32'h55667788, 1, 0, 3, 1,  0, 1, 8'h22, 0, 0, 0);
        vecs[8]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  0, 1, 8'h33, 0, 1, 0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h55, 1, 0, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h66, 0, 0, 0);
        vecs[11] = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h77, 0, 0, 0);
        vecs[12] = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 1, 8'h88, 0, 0, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0);

        @(negedge clk);

        // Table: reset, full beat, EOP beat with empty, non-EOP beat ignoring empty.
        for (int i = 0; i < 14; i++) begin
            rst       = vecs[i].rst;
            ast_valid = vecs[i].valid;
            ast_data  = vecs[i].data;
            ast_sop   = vecs[i].sop;
            ast_eop   = vecs[i].eop;
            ast_empty = vecs[i].empty;
            sym_ready = vecs[i].srdy;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), ast_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_valid", i), sym_valid, vecs[i].e_sv);
            chk($sformatf("v%0d_sop", i), sym_sop, vecs[i].e_sop);
            chk($sformatf("v%0d_eop", i), sym_eop, vecs[i].e_eop);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ov);
            if (vecs[i].e_sv) begin
                chk($sformatf("v%0d_data", i), sym_data, vecs[i].e_data);
            end
        end

        // Source honouring RL=2 against a stalled consumer: fills exactly, no loss.
        reset_dut();
        sent = 0;
        hist = 2'b00;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (hist[1]) begin
                send_beat(beat_word(sent));
                sent++;
            end else begin
                idle_inputs();
            end
            hist = {hist[0], ast_ready};
            @(negedge clk);
        end
        idle_inputs();
        chk("rl_sent", sent, 4);
        chk("rl_ovf", overflow, 1'b0);
        chk("rl_ready_low", ast_ready, 1'b0);
        chk("rl_valid", sym_valid, 1'b1);
        drain(0, 16, "rl");
        chk("rl_ovf_after", overflow, 1'b0);

        // Source ignoring ready: fifth beat is dropped and overflow sticks.
        reset_dut();
        for (int b = 0; b < 5; b++) begin
            send_beat(beat_word(b));
            @(negedge clk);
            if (b == 3) chk("ov_before", overflow, 1'b0);
        end
        idle_inputs();
        chk("ov_set", overflow, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ov_sticky", overflow, 1'b1);
        drain(0, 16, "ov");
        chk("ov_sticky_after_drain", overflow, 1'b1);

        // Push and pop together while full: push is still refused.
        reset_dut();
        for (int b = 0; b < 4; b++) begin
            send_beat(beat_word(b));
            @(negedge clk);
        end
        idle_inputs();
        chk("fp_ovf_pre", overflow, 1'b0);
        sym_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("fp_last_sym", sym_data, sym_of(0, 3));
        chk("fp_last_eop", sym_eop, 1'b1);
        send_beat(beat_word(9));
        @(negedge clk);
        idle_inputs();
        chk("fp_ovf", overflow, 1'b1);
        chk("fp_next_head", sym_data, sym_of(1, 0));
        drain(1, 12, "fp");

        // Push and pop together at occupancy 2: occupancy holds, ready stays low.
        reset_dut();
        for (int b = 0; b < 2; b++) begin
            send_beat(beat_word(b));
            @(negedge clk);
        end
        idle_inputs();
        sym_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        send_beat(beat_word(2));
        @(negedge clk);
        idle_inputs();
        chk("pp_ready", ast_ready, 1'b0);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_head", sym_data, sym_of(1, 0));
        drain(1, 8, "pp");

        // Reset after two symbols of a beat have been consumed.
        reset_dut();
        sym_ready = 1'b1;
        send_beat(32'hA1B2C3D4);
        @(negedge clk);
        idle_inputs();
        chk("mr_s0", sym_data, 8'hA1);
        @(negedge clk);
        chk("mr_s1", sym_data, 8'hB2);
        @(negedge clk);
        chk("mr_s2", sym_data, 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_rst_valid", sym_valid, 1'b0);
        chk("mr_rst_ready", ast_ready, 1'b0);
        chk("mr_rst_sop", sym_sop, 1'b0);
        chk("mr_rst_eop", sym_eop, 1'b0);
        send_beat(32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        chk("mr_ready", ast_ready, 1'b1);
        chk("mr_new_valid", sym_valid, 1'b1);
        chk("mr_new_s0", sym_data, 8'hDE);
        chk("mr_new_sop", sym_sop, 1'b1);
        @(negedge clk);
        chk("mr_new_s1", sym_data, 8'hAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ast_sink_unpacker.md
# ast_sink_unpacker

Avalon-ST sink that consumes multi-symbol beats from an upstream Avalon-ST source (e.g. the Avalon FIFO read port) and emits them one symbol per cycle on a simple valid/ready symbol stream. It honours the source's ready latency with an internal credit-sized beat buffer. It sits at the read end of Avalon-ST data paths, feeding byte-oriented consumers such as serializers and checkers.

## Interface
- DATABITS_PER_SYMBOL, 8, bits per symbol
- SYMBOLS_PER_BEAT, 4, symbols per Avalon beat; WIDTH = product
- READY_LATENCY, 2, cycles from ast_ready_o to the earliest valid beat it permits
- DEPTH, READY_LATENCY+2, beat buffer entries; must be ≥ READY_LATENCY+2
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- ast_data_i  in  WIDTH  beat data; symbol 0 in the MSBs
- ast_valid_i  in  1  beat valid
- ast_sop_i / ast_eop_i  in  1  start / end of packet
- ast_empty_i  in  clog2(SYMBOLS_PER_BEAT)  unused symbols (LS end) in EOP beat
- ast_ready_o  out  1  sink ready, registered
- sym_data_o  out  DATABITS_PER_SYMBOL  current symbol
- sym_valid_o  out  1  symbol valid
- sym_ready_i  in  1  consumer ready
- sym_sop_o / sym_eop_o  out  1  first / last symbol of packet
- overflow_o  out  1  sticky: beat arrived while buffer full

## Operation
- Beat accepted whenever ast_valid_i=1 and buffer not full, independent of current ast_ready_o (ready-latency semantics); beat stored as {data, sop, eop, empty}.
- ast_ready_o next value = 1 iff occupancy after this cycle's push/pop ≤ DEPTH-1-READY_LATENCY.
- Valid beat while buffer full: beat dropped, overflow_o set; cleared only by rst_i.
- Unpacker: symbol index idx (0..SYMBOLS_PER_BEAT-1) over head beat; sym_data_o = symbol idx of head; sym_valid_o = buffer not empty.
- Symbol handshake (sym_valid_o & sym_ready_i): if idx is last symbol of beat, pop head and idx←0; else idx←idx+1.
- Last symbol = SYMBOLS_PER_BEAT-1, or SYMBOLS_PER_BEAT-1-empty on EOP beat; empty ignored on non-EOP beats.
- sym_sop_o = head.sop & idx==0; sym_eop_o = head.eop & idx==last.
- Simultaneous push and pop: both occur; occupancy unchanged.
- No packet-framing checks; SOP/EOP passed through as received.

## Timing
- Reset values: ast_ready_o=0, sym_valid_o=0, sym_sop_o=0, sym_eop_o=0, overflow_o=0, idx=0, buffer empty; sym_data_o don't-care.
- First cycle after rst_i deasserts: ast_ready_o=1.
- Latency: beat sampled at edge N → its symbol 0 on sym_data_o with sym_valid_o=1 after edge N (cycle N+1) if buffer was empty.
- Full-beat throughput: 1 symbol/cycle while sym_ready_i=1; a beat drains in SYMBOLS_PER_BEAT cycles.
- rst_i mid-packet: buffer flushed, idx cleared, partial beat discarded; outputs at reset values next cycle.
- Buffer wrap-around via modulo-DEPTH pointers; occupancy counter width clog2(DEPTH+1).

## Structure
- Package ast_pkg: ast_beat_t struct {data, sop, eop, empty}, localparams WIDTH and EMPTY_W derived from symbol parameters.
- Sub-module ast_beat_buf: synchronous DEPTH-entry FIFO of ast_beat_t with push, pop, full, empty, occupancy outputs; top holds ready/credit logic, unpack index and overflow flag.

## Test plan
- Reset then single beat 0xA1B2C3D4, sop=eop=1, empty=0, sym_ready_i=1 → symbols A1,B2,C3,D4 in cycles N+1..N+4; sop on A1, eop on D4.
- EOP beat 0x11223300 with empty=1 → symbols 11,22,33 only; eop on 33; next beat starts at its symbol 0.
- Continuous beats with sym_ready_i=0: ast_ready_o drops once occupancy >1 (DEPTH=4, RL=2); source honouring RL=2 delivers 2 in-flight beats; no loss, overflow_o=0; release → all symbols in order.
- Protocol violation: valid beats driven every cycle ignoring ast_ready_o, sym_ready_i=0 → 5th beat dropped, overflow_o=1 and stays 1.
- Simultaneous push and pop at occupancy DEPTH → push accepted (pop frees slot same cycle? no: full check uses pre-pop state) → beat dropped, overflow_o=1; at occupancy 2 → occupancy stays 2.
- rst_i asserted after 2 of 4 symbols → next cycle sym_valid_o=0, ast_ready_o=0; following cycle ast_ready_o=1; new packet starts at symbol 0.
